// File: rtl/mining_cmd_scheduler.sv
// mining_cmd_scheduler: runs host commands, sweeps nonces through one SHA-256 core,
// and returns status / found-nonce bytes over a valid/ack byte handshake.
module mining_cmd_scheduler #(
    parameter logic [31:0] NONCE_LAST   = 32'hFFFF_FFFF,
    parameter int          TARGET_ZEROS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ready,
    input  logic [7:0]   command,
    input  logic [15:0]  data_count,
    input  logic [255:0] buffer,
    output logic         hash_start,
    output logic [255:0] hash_mid,
    output logic [95:0]  hash_tail,
    output logic [31:0]  hash_nonce,
    input  logic         hash_done,
    input  logic [255:0] hash_out,
    output logic [7:0]   tx_byte,
    output logic         tx_valid,
    input  logic         tx_ack,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, REPLY} state_t;
    state_t state, state_d;
    logic prev_ready, stop_flag, found_flag, drop_flag, pend_done, resume;
    logic [TARGET_ZEROS-1:0] digest;
    logic [39:0] reply_buf;
    logic [2:0] reply_cnt;
    logic cmd_edge, accept, drop, hit, last;
    logic [7:0] reply_code;
    logic unused_ok;
    assign unused_ok = ^{data_count, hash_out[255-TARGET_ZEROS:0]};
    assign cmd_edge = ready & ~prev_ready;
    assign accept = cmd_edge && (state == IDLE || (state == WAIT && (command == 8'd4 || command == 8'd5)));
    assign drop = cmd_edge & ~accept;
    assign hit = digest == '0;
    assign last = hash_nonce == NONCE_LAST;
    assign reply_code = command == 8'd5 ? {drop_flag, 5'b0, found_flag, busy}
                      : (command <= 8'd2 || command == 8'd4) ? 8'h4B : 8'h45;
    assign hash_start = state == ISSUE;
    assign tx_valid = state == REPLY;
    assign tx_byte = reply_buf[39:32];
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = !accept ? IDLE : command == 8'd3 ? ISSUE : REPLY;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (accept && command == 8'd5) ? REPLY : (hash_done || pend_done) ? CHECK : WAIT;
            CHECK:   state_d = (hit || stop_flag || last) ? REPLY : ISSUE;
            REPLY:   state_d = (tx_ack && reply_cnt == 3'd1) ? (resume ? WAIT : IDLE) : REPLY;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ready <= 1'b0;
            hash_mid   <= '0;
            hash_tail  <= '0;
            hash_nonce <= '0;
            stop_flag  <= 1'b0;
            found_flag <= 1'b0;
            drop_flag  <= 1'b0;
            pend_done  <= 1'b0;
            resume     <= 1'b0;
            digest     <= '0;
            reply_buf  <= '0;
            reply_cnt  <= '0;
        end else begin
            prev_ready <= ready;
            if (drop) drop_flag <= 1'b1;
            if (hash_done && (state == WAIT || (state == REPLY && resume))) digest <= hash_out[255 -: TARGET_ZEROS];
            // a digest that lands while a mid-sweep STATUS is being sent is replayed on return to WAIT
            if (hash_done && ((state == REPLY && resume) || (state == WAIT && state_d == REPLY))) pend_done <= 1'b1;
            else if (state_d == CHECK) pend_done <= 1'b0;
            if (accept) begin
                case (command)
                    8'd1: hash_mid <= buffer;
                    8'd2: hash_tail <= buffer[95:0];
                    8'd3: begin
                        hash_nonce <= '0;
                        stop_flag  <= 1'b0;
                        found_flag <= 1'b0;
                    end
                    8'd4: stop_flag <= 1'b1;
                    8'd5: drop_flag <= 1'b0;
                    default: ;
                endcase
                resume    <= state == WAIT;
                reply_buf <= {reply_code, 32'b0};
                reply_cnt <= 3'd1;
            end
            if (state == CHECK) begin
                resume <= 1'b0;
                if (hit) begin
                    found_flag <= 1'b1;
                    reply_buf  <= {8'h46, hash_nonce};
                    reply_cnt  <= 3'd5;
                end else if (stop_flag || last) begin
                    reply_buf <= {stop_flag ? 8'h53 : 8'h58, 32'b0};
                    reply_cnt <= 3'd1;
                end else hash_nonce <= hash_nonce + 32'd1;
            end
            if (state == REPLY && tx_ack) begin
                reply_buf <= reply_buf << 8;
                reply_cnt <= reply_cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mining_cmd_scheduler.sv
// tb_mining_cmd_scheduler: randomized commands and sweeps against a transaction-level model
// of replies, nonce sequence and loaded registers, with a core model and random-ack transmitter.
module tb_mining_cmd_scheduler;
    localparam logic [31:0] NL = 32'd7;
    logic clk = 0, rst = 1, ready = 0, hash_done = 0, tx_ack = 0;
    logic [7:0] command = 0;
    logic [15:0] data_count = 0;
    logic [255:0] buffer = '0, hash_out = '0;
    logic hash_start, tx_valid, busy;
    logic [255:0] hash_mid;
    logic [95:0] hash_tail;
    logic [31:0] hash_nonce;
    logic [7:0] tx_byte;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    mining_cmd_scheduler #(.NONCE_LAST(NL), .TARGET_ZEROS(32)) dut (
        .clk(clk), .rst(rst), .ready(ready), .command(command), .data_count(data_count),
        .buffer(buffer), .hash_start(hash_start), .hash_mid(hash_mid), .hash_tail(hash_tail),
        .hash_nonce(hash_nonce), .hash_done(hash_done), .hash_out(hash_out),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ack(tx_ack), .busy(busy)
    );

    logic [7:0] exp_tx[$];
    logic [31:0] next_nonce = 0, sweep_last = 0, hit_nonce = 32'hFFFF_FFFF, job_nonce = 0;
    logic sweep_on = 0, stopped = 0, found_m = 0, drop_m = 0, job_busy = 0, start_evt = 0;
    logic hold_chk = 0, ack_force = 0, mon_ack = 0;
    logic [7:0] hold_byte = 0;
    logic [39:0] rx_hist = 0;
    logic [255:0] mid_m = '0;
    logic [95:0] tail_m = '0;
    int job_cnt = 0, starts = 0, ack_mode = 0;

    function automatic void chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // transmitter and hash-core models; everything sampled on the falling edge
    always @(negedge clk) begin
        if (hold_chk) chk("tx_hold", {tx_valid, tx_byte}, {1'b1, hold_byte});
        mon_ack = ack_mode == 0 ? ack_force : ($urandom_range(0, 2) == 0);
        tx_ack = mon_ack;
        if (tx_valid && mon_ack) begin
            rx_hist = {rx_hist[31:0], tx_byte};
            if (exp_tx.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_extra: got byte %0h expected none", tx_byte);
            end else chk("tx_byte", tx_byte, exp_tx.pop_front());
        end
        hold_chk = tx_valid && !mon_ack;
        hold_byte = tx_byte;
        hash_done = 0;
        start_evt = 0;
        if (job_busy) begin
            job_cnt = job_cnt - 1;
            if (job_cnt == 0) begin
                job_busy = 0;
                hash_done = 1;
                hash_out = rand256();
                if (job_nonce == hit_nonce) hash_out[255:223] = 33'h1;
                else hash_out[255:224] = $urandom_range(0, 1) ? 32'h1 : ($urandom | 32'h1);
                if (sweep_on && job_nonce == sweep_last) begin
                    sweep_on = 0;
                    if (job_nonce == hit_nonce) begin
                        found_m = 1;
                        exp_tx.push_back(8'h46);
                        for (int i = 3; i >= 0; i--) exp_tx.push_back(job_nonce[i*8 +: 8]);
                    end else exp_tx.push_back(stopped ? 8'h53 : 8'h58);
                end
            end
        end
        if (hash_start) begin
            start_evt = 1;
            starts++;
            if (!sweep_on || next_nonce > sweep_last) begin
                tests++;
                fails++;
                $display("FAIL hash_start: got start nonce %0h expected no start", hash_nonce);
            end else chk("hash_nonce", hash_nonce, next_nonce);
            next_nonce = next_nonce + 1;
            job_nonce = hash_nonce;
            job_busy = 1;
            job_cnt = $urandom_range(3, 6);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [255:0] b);
        command = c;
        buffer = b;
        data_count = 16'($urandom_range(0, 64));
        ready = 1;
        tick();
        ready = 0;
        tick();
    endtask

    task automatic cmd(input logic [7:0] c, input logic [255:0] b, input logic in_wait);
        if (c == 8'd1) mid_m = b;
        if (c == 8'd2) tail_m = b[95:0];
        if (c == 8'd5) begin
            exp_tx.push_back({drop_m, 5'b0, found_m, in_wait});
            drop_m = 0;
        end else if (c == 8'd3) begin
            found_m = 0;
            stopped = 0;
            next_nonce = 0;
            starts = 0;
            sweep_last = hit_nonce > NL ? NL : hit_nonce;
            sweep_on = 1;
        end else if (c == 8'd4 && in_wait) begin
            stopped = 1;
            sweep_last = job_nonce;
        end else exp_tx.push_back((c <= 8'd2 || c == 8'd4) ? 8'h4B : 8'h45);
        send(c, b);
    endtask

    task automatic wait_start(input logic [31:0] n);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(start_evt && job_nonce == n) && k < 300);
        if (k >= 300) begin
            tests++;
            fails++;
            $display("FAIL wait_start: got no start for nonce %0h expected one", n);
        end
        tick();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || sweep_on || exp_tx.size() != 0) && k < 3000) begin
            tick();
            k++;
        end
        if (k >= 3000) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got busy=%0d pending=%0d expected idle", name, busy, exp_tx.size());
            exp_tx.delete();
            sweep_on = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] b;
        int kind;
        repeat (3) tick();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hash_start", hash_start, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_mid", hash_mid, 0);
        chk("rst_tail", hash_tail, 0);
        chk("rst_nonce", hash_nonce, 0);
        rst = 0;
        tick();
        cmd(8'd0, '0, 0);
        chk("ping_valid", tx_valid, 1);
        chk("ping_byte", tx_byte, 8'h4B);
        chk("ping_busy", busy, 1);
        tick();
        tick();
        chk("ping_held", {tx_valid, tx_byte}, 9'h14B);
        ack_force = 1;
        tick();
        ack_force = 0;
        tick();
        chk("ping_valid_fall", tx_valid, 0);
        chk("ping_busy_fall", busy, 0);
        ack_mode = 1;
        cmd(8'd1, {32{8'hA5}}, 0);
        wait_idle("load_mid");
        chk("load_mid", hash_mid, {32{8'hA5}});
        cmd(8'd2, {160'h0, 96'h1234_5678_9ABC_DEF0_1357_9BDF}, 0);
        wait_idle("load_tail");
        chk("load_tail", hash_tail, 96'h1234_5678_9ABC_DEF0_1357_9BDF);
        chk("load_mid_kept", hash_mid, {32{8'hA5}});
        chk("load_replies", rx_hist[15:0], 16'h4B4B);
        cmd(8'd9, '0, 0);
        cmd(8'd5, '0, 0);
        wait_idle("bad_status");
        chk("bad_then_status", rx_hist[15:0], 16'h4500);
        hit_nonce = 5;
        cmd(8'd3, '0, 0);
        wait_idle("hit");
        chk("hit_starts", starts, 6);
        chk("hit_reply", rx_hist, 40'h46_0000_0005);
        cmd(8'd5, '0, 0);
        wait_idle("hit_status");
        chk("hit_status", rx_hist[7:0], 8'h02);
        hit_nonce = 32'hFFFF_FFFF;
        cmd(8'd3, '0, 0);
        wait_idle("exhaust");
        chk("exhaust_starts", starts, 8);
        chk("exhaust_nonce", hash_nonce, NL);
        cmd(8'd5, '0, 0);
        wait_idle("exhaust_status");
        chk("exhaust_replies", rx_hist[15:0], 16'h5800);
        cmd(8'd3, '0, 0);
        wait_start(2);
        cmd(8'd5, '0, 1);
        wait_start(4);
        cmd(8'd4, '0, 1);
        wait_idle("stop");
        chk("stop_starts", starts, 5);
        chk("stop_replies", rx_hist[15:0], 16'h0153);
        hit_nonce = 0;
        cmd(8'd3, '0, 0);
        wait_idle("hit0");
        chk("hit0_starts", starts, 1);
        chk("hit0_reply", rx_hist, 40'h46_0000_0000);
        ack_mode = 0;
        cmd(8'd0, '0, 0);
        send(8'd1, '1);
        drop_m = 1;
        chk("drop_mid_kept", hash_mid, {32{8'hA5}});
        ack_mode = 1;
        wait_idle("drop");
        cmd(8'd5, '0, 0);
        cmd(8'd5, '0, 0);
        wait_idle("drop_status");
        chk("drop_status", rx_hist[15:0], 16'h8202);
        hit_nonce = 32'hFFFF_FFFF;
        ack_mode = 0;
        cmd(8'd3, '0, 0);
        wait_start(1);
        rst = 1;
        sweep_on = 0;
        exp_tx.delete();
        tick();
        chk("rst_wait_valid", tx_valid, 0);
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_nonce", hash_nonce, 0);
        chk("rst_wait_mid", hash_mid, 0);
        rst = 0;
        mid_m = '0;
        tail_m = '0;
        found_m = 0;
        drop_m = 0;
        repeat (12) tick();
        chk("rst_done_ignored", busy, 0);
        ack_mode = 1;
        cmd(8'd5, '0, 0);
        wait_idle("post_rst");
        chk("post_rst_status", rx_hist[7:0], 8'h00);
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 5);
            b = rand256();
            case (kind)
                0: cmd(8'd0, b, 0);
                1: cmd(8'd1, b, 0);
                2: cmd(8'd2, b, 0);
                3: cmd(8'd5, b, 0);
                4: cmd(8'($urandom_range(6, 255)), b, 0);
                default: begin
                    hit_nonce = $urandom_range(0, 10);
                    cmd(8'd3, b, 0);
                    if (hit_nonce > 1 && $urandom_range(0, 1) == 1) begin
                        wait_start(1);
                        cmd(8'd5, b, 1);
                    end
                end
            endcase
            wait_idle("random");
            chk("rand_mid", hash_mid, mid_m);
            chk("rand_tail", hash_tail, tail_m);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
